// File: rtl/adler32_stream.sv
// Streaming Adler-32 engine: BYTES lanes per beat with per-lane keep, A/B sums mod MOD,
// result held on a valid/ready output handshake until the consumer takes it.
//
// state | meaning
// IDLE  | no bytes of the current message yet, A = A_INIT, B = 0
// ACCUM | at least one beat of the current message accepted
// DONE  | checksum/byte_count hold a completed result, input stalled
module adler32_stream #(
    parameter int BYTES  = 4,
    parameter int MOD    = 65521,
    parameter int A_INIT = 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic [8*BYTES-1:0]   data,
    input  logic [BYTES-1:0]     data_keep,
    input  logic                 last_data,
    output logic                 checksum_valid,
    input  logic                 checksum_ready,
    output logic [31:0]          checksum,
    output logic [31:0]          byte_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [16:0] MOD_W    = 17'(MOD);
    localparam logic [15:0] A_INIT_W = 16'(A_INIT);

    state_t      state_q, state_nxt;
    logic [15:0] a_q, b_q, a_nxt, b_nxt;
    logic [31:0] cnt_q, cnt_nxt;
    logic [31:0] checksum_q, byte_count_q;
    logic        beat_accept, result_taken;

    // Operands are always below 2*MOD when MOD >= 256, so one conditional subtract is exact;
    // tiny moduli fall back to a full remainder.
    function automatic logic [15:0] reduce(input logic [16:0] x);
        logic [16:0] r;
        if (MOD_W > 17'd255)
            r = (x >= MOD_W) ? (x - MOD_W) : x;
        else
            r = x % MOD_W;
        return 16'(r);
    endfunction

    always_comb begin
        a_nxt   = a_q;
        b_nxt   = b_q;
        cnt_nxt = cnt_q;
        for (int i = 0; i < BYTES; i++) begin
            if (data_keep[i]) begin
                a_nxt   = reduce({1'b0, a_nxt} + {9'd0, data[8*i +: 8]});
                b_nxt   = reduce({1'b0, b_nxt} + {1'b0, a_nxt});
                cnt_nxt = cnt_nxt + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt      = state_q;
        data_ready     = 1'b0;
        checksum_valid = 1'b0;
        beat_accept    = 1'b0;
        result_taken   = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    beat_accept = 1'b1;
                    state_nxt   = last_data ? DONE : ACCUM;
                end
            end
            DONE: begin
                checksum_valid = 1'b1;
                if (checksum_ready) begin
                    result_taken = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= A_INIT_W;
            b_q          <= 16'd0;
            cnt_q        <= 32'd0;
            checksum_q   <= 32'd0;
            byte_count_q <= 32'd0;
        end else begin
            state_q <= state_nxt;
            if (beat_accept) begin
                a_q   <= a_nxt;
                b_q   <= b_nxt;
                cnt_q <= cnt_nxt;
                if (last_data) begin
                    checksum_q   <= {b_nxt, a_nxt};
                    byte_count_q <= cnt_nxt;
                end
            end else if (result_taken) begin
                a_q   <= A_INIT_W;
                b_q   <= 16'd0;
                cnt_q <= 32'd0;
            end
        end
    end

    assign checksum   = checksum_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_adler32_stream.sv
// Directed bench for adler32_stream (BYTES=4): known Adler-32 vectors, back-pressure and reset.
module tb_adler32_stream;

    logic        clock = 1'b0;
    logic        rst;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data;
    logic [3:0]  data_keep;
    logic        last_data;
    logic        checksum_valid;
    logic        checksum_ready;
    logic [31:0] checksum;
    logic [31:0] byte_count;

    int n_cmp = 0;
    int n_err = 0;

    adler32_stream #(.BYTES(4), .MOD(65521), .A_INIT(1)) dut (
        .clock          (clock),
        .rst            (rst),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .data           (data),
        .data_keep      (data_keep),
        .last_data      (last_data),
        .checksum_valid (checksum_valid),
        .checksum_ready (checksum_ready),
        .checksum       (checksum),
        .byte_count     (byte_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    // Presents one beat; it is accepted on the rising edge after data_ready is seen high.
    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        @(negedge clock);
        data       = d;
        data_keep  = k;
        last_data  = l;
        data_valid = 1'b1;
        n = 0;
        while (!data_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!data_ready) check_eq("beat_ready_timeout", {31'd0, data_ready}, 32'd1);
    endtask

    // Called right after the last beat: checks one-cycle latency, the result, then accepts it.
    task automatic finish_msg(input string tag, input logic [31:0] exp_cs, input logic [31:0] exp_cnt);
        @(negedge clock);
        data_valid = 1'b0;
        data_keep  = 4'd0;
        last_data  = 1'b0;
        check_eq({tag, "_valid"}, {31'd0, checksum_valid}, 32'd1);
        check_eq({tag, "_ready_low"}, {31'd0, data_ready}, 32'd0);
        check_eq({tag, "_cs"}, checksum, exp_cs);
        check_eq({tag, "_cnt"}, byte_count, exp_cnt);
        checksum_ready = 1'b1;
        @(negedge clock);
        checksum_ready = 1'b0;
        check_eq({tag, "_idle_ready"}, {31'd0, data_ready}, 32'd1);
        check_eq({tag, "_idle_valid"}, {31'd0, checksum_valid}, 32'd0);
        check_eq({tag, "_cs_kept"}, checksum, exp_cs);
    endtask

    task automatic send_abc(input string tag);
        beat(pack4(8'h61, 8'h62, 8'h63, 8'h00), 4'b0111, 1'b1);
        finish_msg(tag, 32'h024D0127, 32'd3);
    endtask

    initial begin
        rst            = 1'b1;
        data_valid     = 1'b0;
        data           = '0;
        data_keep      = '0;
        last_data      = 1'b0;
        checksum_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst_ready", {31'd0, data_ready}, 32'd1);
        check_eq("rst_valid", {31'd0, checksum_valid}, 32'd0);
        check_eq("rst_cs", checksum, 32'd0);
        check_eq("rst_cnt", byte_count, 32'd0);
        rst = 1'b0;

        send_abc("abc");

        beat(pack4(8'h57, 8'h69, 8'h6B, 8'h69), 4'b1111, 1'b0);
        beat(pack4(8'h70, 8'h65, 8'h64, 8'h69), 4'b1111, 1'b0);
        beat(pack4(8'h61, 8'h00, 8'h00, 8'h00), 4'b0001, 1'b1);
        finish_msg("wiki", 32'h11E60398, 32'd9);

        for (int i = 0; i < 75; i++)
            beat(32'hFFFF_FFFF, 4'b1111, (i == 74));
        finish_msg("ff300", 32'hB90F2AE4, 32'd300);

        beat(32'hDEAD_BEEF, 4'b0000, 1'b1);
        finish_msg("empty", 32'h0000_0001, 32'd0);

        // Result held under back-pressure while a stray beat waits at the input.
        beat(pack4(8'h00, 8'h00, 8'h61, 8'h00), 4'b0100, 1'b1);
        @(negedge clock);
        data_valid = 1'b0;
        check_eq("lane2_valid", {31'd0, checksum_valid}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin
                data       = 32'hFFFF_FFFF;
                data_keep  = 4'b1111;
                last_data  = 1'b1;
                data_valid = 1'b1;
            end
            if (c == 9) data_valid = 1'b0;
            check_eq("hold_ready", {31'd0, data_ready}, 32'd0);
            check_eq("hold_cs", checksum, 32'h0062_0062);
            check_eq("hold_cnt", byte_count, 32'd1);
            @(negedge clock);
        end
        check_eq("hold_still_valid", {31'd0, checksum_valid}, 32'd1);
        checksum_ready = 1'b1;
        @(negedge clock);
        checksum_ready = 1'b0;
        check_eq("release_ready", {31'd0, data_ready}, 32'd1);
        send_abc("abc_after_hold");

        // Reset mid-message discards the partial sums.
        beat(pack4(8'h11, 8'h22, 8'h33, 8'h44), 4'b1111, 1'b0);
        beat(pack4(8'h55, 8'h66, 8'h77, 8'h88), 4'b1111, 1'b0);
        @(negedge clock);
        data_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        send_abc("abc_after_rst");

        // Reset while a result is held drops it.
        beat(pack4(8'h61, 8'h62, 8'h63, 8'h00), 4'b0111, 1'b1);
        @(negedge clock);
        data_valid = 1'b0;
        check_eq("done_rst_pre_valid", {31'd0, checksum_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        check_eq("done_rst_valid", {31'd0, checksum_valid}, 32'd0);
        check_eq("done_rst_cs", checksum, 32'd0);
        check_eq("done_rst_cnt", byte_count, 32'd0);
        check_eq("done_rst_ready", {31'd0, data_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
